// File: rtl/cache_l2_pkg.sv
// rtl/cache_l2_pkg.sv - shared types and geometry helpers for the L2 cache
package cache_l2_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    function automatic int calc_off_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int calc_idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int calc_tag_w(input int addr_w, input int sets, input int line_words);
        return addr_w - $clog2(sets) - $clog2(line_words);
    endfunction

    // Word address of the first word of the line holding a.
    function automatic logic [63:0] line_base(input logic [63:0] a, input int off_w);
        return (a >> off_w) << off_w;
    endfunction

endpackage

// File: rtl/cache_l2_way.sv
// rtl/cache_l2_way.sv - one way: valid bits, tag array and line data array
module cache_l2_way #(
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 8,
    parameter int DATA_W     = 32,
    parameter int TAG_W      = 25,
    parameter int IDX_W      = $clog2(SETS),
    parameter int OFF_W      = $clog2(LINE_WORDS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [IDX_W-1:0]             rd_idx,
    output logic                         rd_valid,
    output logic [TAG_W-1:0]             rd_tag,
    output logic [LINE_WORDS*DATA_W-1:0] rd_line,
    input  logic                         we,
    input  logic [IDX_W-1:0]             w_idx,
    input  logic [OFF_W-1:0]             w_off,
    input  logic [DATA_W-1:0]            w_data,
    input  logic                         clr_en,
    input  logic [IDX_W-1:0]             clr_idx,
    input  logic                         set_en,
    input  logic [IDX_W-1:0]             set_idx,
    input  logic [TAG_W-1:0]             set_tag
);

    logic [SETS-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0]  tag_mem  [SETS];
    logic [DATA_W-1:0] data_mem [SETS][LINE_WORDS];

    always_comb begin
        valid_d = valid_q;
        if (clr_en) valid_d[clr_idx] = 1'b0;
        if (set_en) valid_d[set_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) valid_q <= '0;
        else     valid_q <= valid_d;
    end

    always_ff @(posedge clk) begin
        if (set_en) tag_mem[set_idx] <= set_tag;
        if (we)     data_mem[w_idx][w_off] <= w_data;
    end

    always_comb begin
        rd_valid = valid_q[rd_idx];
        rd_tag   = tag_mem[rd_idx];
        for (int w = 0; w < LINE_WORDS; w++) begin
            rd_line[w*DATA_W +: DATA_W] = data_mem[rd_idx][w];
        end
    end

endmodule

// File: rtl/cache_l2_assoc.sv
// rtl/cache_l2_assoc.sv - set-associative write-through L2 cache with line refill FSM
module cache_l2_assoc import cache_l2_pkg::*; #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int SETS       = 16,
    parameter int WAYS       = 2,
    parameter int LINE_WORDS = 8,
    parameter int L1_WORDS   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rd_req,
    input  logic                       wr_req,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [DATA_W-1:0]          wdata,
    output logic                       stall,
    output logic [DATA_W-1:0]          rdata,
    output logic [L1_WORDS*DATA_W-1:0] l1_line,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic                       mem_ready,
    input  logic                       mem_rvalid,
    input  logic [DATA_W-1:0]          mem_rdata
);

    localparam int OFF_W = calc_off_w(LINE_WORDS);
    localparam int IDX_W = calc_idx_w(SETS);
    localparam int TAG_W = calc_tag_w(ADDR_W, SETS, LINE_WORDS);
    localparam int L1_SH = $clog2(L1_WORDS);
    localparam int CNT_W = OFF_W + 1;

    logic [OFF_W-1:0] a_off;
    logic [IDX_W-1:0] a_idx, f_idx;
    logic [TAG_W-1:0] a_tag, f_tag;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  issue_q, issue_d, rx_q, rx_d;
    logic              victim_q, victim_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [SETS-1:0]   lru_q, lru_d;

    logic                         way_valid [WAYS];
    logic [TAG_W-1:0]             way_tag   [WAYS];
    logic [LINE_WORDS*DATA_W-1:0] way_line  [WAYS];
    logic [WAYS-1:0]              way_we, way_clr, way_set, hit_w;
    logic [IDX_W-1:0]             way_widx;
    logic [OFF_W-1:0]             way_woff;
    logic [DATA_W-1:0]            way_wdata;
    logic                         hit, hit_way;
    logic [LINE_WORDS*DATA_W-1:0] sel_line;
    int                           sub_base;

    assign a_off = addr[OFF_W-1:0];
    assign a_idx = addr[OFF_W +: IDX_W];
    assign a_tag = addr[ADDR_W-1 -: TAG_W];
    assign f_idx = base_q[OFF_W +: IDX_W];
    assign f_tag = base_q[ADDR_W-1 -: TAG_W];

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        cache_l2_way #(
            .SETS(SETS), .LINE_WORDS(LINE_WORDS), .DATA_W(DATA_W), .TAG_W(TAG_W)
        ) u_way (
            .clk(clk), .rst(rst),
            .rd_idx(a_idx), .rd_valid(way_valid[w]), .rd_tag(way_tag[w]), .rd_line(way_line[w]),
            .we(way_we[w]), .w_idx(way_widx), .w_off(way_woff), .w_data(way_wdata),
            .clr_en(way_clr[w]), .clr_idx(a_idx),
            .set_en(way_set[w]), .set_idx(f_idx), .set_tag(f_tag)
        );
    end

    always_comb begin
        for (int w = 0; w < WAYS; w++) hit_w[w] = way_valid[w] && (way_tag[w] == a_tag);
        hit      = |hit_w;
        hit_way  = (WAYS == 2) ? hit_w[WAYS-1] : 1'b0;
        sel_line = way_line[hit_way];
        sub_base = (int'(a_off) >> L1_SH) << L1_SH;
        rdata    = '0;
        l1_line  = '0;
        if (!rst && state_q == ST_IDLE && hit) begin
            rdata = sel_line[a_off*DATA_W +: DATA_W];
            for (int i = 0; i < L1_WORDS; i++) begin
                l1_line[i*DATA_W +: DATA_W] = sel_line[(sub_base+i)*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        issue_d   = issue_q;
        rx_d      = rx_q;
        victim_d  = victim_q;
        base_d    = base_q;
        lru_d     = lru_q;
        stall     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        way_we    = '0;
        way_clr   = '0;
        way_set   = '0;
        way_widx  = a_idx;
        way_woff  = a_off;
        way_wdata = wdata;
        // Outputs stay quiet while reset is held, even if a request is still asserted.
        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (wr_req) begin
                        mem_req   = 1'b1;
                        mem_we    = 1'b1;
                        mem_addr  = addr;
                        mem_wdata = wdata;
                        stall     = !mem_ready;
                        if (mem_ready && hit) begin
                            way_we[hit_way] = 1'b1;
                            lru_d[a_idx]    = ~hit_way;
                        end
                    end else if (rd_req) begin
                        if (hit) begin
                            lru_d[a_idx] = ~hit_way;
                        end else begin
                            stall = 1'b1;
                            if (!way_valid[0])                           victim_d = 1'b0;
                            else if (WAYS == 2 && !way_valid[WAYS-1])    victim_d = 1'b1;
                            else                                         victim_d = (WAYS == 2) ? lru_q[a_idx] : 1'b0;
                            way_clr[victim_d] = 1'b1;
                            base_d  = ADDR_W'(line_base(64'(addr), OFF_W));
                            issue_d = '0;
                            rx_d    = '0;
                            state_d = ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    stall   = 1'b1;
                    mem_req = issue_q < CNT_W'(LINE_WORDS);
                    if (mem_req) mem_addr = base_q + ADDR_W'(issue_q);
                    if (mem_req && mem_ready) issue_d = issue_q + 1'b1;
                    if (mem_rvalid) begin
                        way_we[victim_q] = 1'b1;
                        way_widx  = f_idx;
                        way_woff  = rx_q[OFF_W-1:0];
                        way_wdata = mem_rdata;
                        rx_d      = rx_q + 1'b1;
                        if (rx_q == CNT_W'(LINE_WORDS-1)) begin
                            way_set[victim_q] = 1'b1;
                            lru_d[f_idx]      = ~victim_q;
                            state_d           = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            issue_q  <= '0;
            rx_q     <= '0;
            victim_q <= 1'b0;
            base_q   <= '0;
            lru_q    <= '0;
        end else begin
            state_q  <= state_d;
            issue_q  <= issue_d;
            rx_q     <= rx_d;
            victim_q <= victim_d;
            base_q   <= base_d;
            lru_q    <= lru_d;
        end
    end

endmodule

// File: tb/tb_cache_l2_assoc.sv
// tb/tb_cache_l2_assoc.sv - directed self-checking bench for cache_l2_assoc
module tb_cache_l2_assoc;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int L1W = 4;

    logic              clk, rst, rd_req, wr_req, stall;
    logic [AW-1:0]     addr, mem_addr;
    logic [DW-1:0]     wdata, rdata, mem_wdata, mem_rdata;
    logic [L1W*DW-1:0] l1_line;
    logic              mem_req, mem_we, mem_ready, mem_rvalid;

    cache_l2_assoc dut (
        .clk(clk), .rst(rst), .rd_req(rd_req), .wr_req(wr_req), .addr(addr), .wdata(wdata),
        .stall(stall), .rdata(rdata), .l1_line(l1_line),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [DW-1:0] wmem [logic [AW-1:0]];
    logic [AW-1:0] rq[$];
    logic [AW-1:0] issued[$];
    int            n_rd_acc = 0, n_wr_acc = 0, n_rv = 0, ready_hold = 0;
    bit            rand_mode = 1'b0;
    logic [AW-1:0] last_wa = '0;
    logic [DW-1:0] last_wd = '0;

    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        if (wmem.exists(a)) return wmem[a];
        return DW'(a);
    endfunction

    function automatic logic [127:0] exp_l1(input logic [AW-1:0] b);
        logic [127:0] v = '0;
        for (int i = 0; i < L1W; i++) v[i*DW +: DW] = DW'(b) + DW'(i);
        return v;
    endfunction

    // Memory model: set ready/rvalid for the cycle at negedge, record acceptance once inputs settle.
    always @(negedge clk) begin
        if (ready_hold > 0) begin
            mem_ready = 1'b0;
            ready_hold--;
        end else begin
            mem_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (rq.size() > 0 && (!rand_mode || $urandom_range(0, 2) != 0)) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_val(rq.pop_front());
            n_rv++;
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
        end
        #1;
        if (mem_req && mem_ready) begin
            if (mem_we) begin
                wmem[mem_addr] = mem_wdata;
                last_wa = mem_addr;
                last_wd = mem_wdata;
                n_wr_acc++;
            end else begin
                rq.push_back(mem_addr);
                issued.push_back(mem_addr);
                n_rd_acc++;
            end
        end
    end

    task automatic do_read(input logic [AW-1:0] a, output int stalls,
                           output logic [DW-1:0] rd, output logic [L1W*DW-1:0] l1);
        stalls = 0;
        rd     = '0;
        l1     = '0;
        addr   = a;
        rd_req = 1'b1;
        for (int c = 0; c < 300; c++) begin
            #2;
            if (!stall) begin
                rd = rdata;
                l1 = l1_line;
                break;
            end
            stalls++;
            @(negedge clk);
        end
        chk("rd_timeout", 128'(stalls < 300), 128'(1));
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input int hold, output int stalls);
        #2;
        ready_hold = hold;
        @(negedge clk);
        stalls = 0;
        addr   = a;
        wdata  = d;
        wr_req = 1'b1;
        for (int c = 0; c < 300; c++) begin
            #2;
            if (!stall) break;
            stalls++;
            @(negedge clk);
        end
        chk("wr_timeout", 128'(stalls < 300), 128'(1));
        @(negedge clk);
        wr_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int            st, base, nrd, nwr, ist;
        logic [DW-1:0] rd;
        logic [127:0]  l1;

        rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0; addr = '0; wdata = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_stall", 128'(stall), 128'(0));
        chk("rst_mem_req", 128'(mem_req), 128'(0));
        chk("rst_mem_we", 128'(mem_we), 128'(0));
        chk("rst_mem_addr", 128'(mem_addr), 128'(0));
        chk("rst_mem_wdata", 128'(mem_wdata), 128'(0));
        chk("rst_rdata", 128'(rdata), 128'(0));
        chk("rst_l1_line", 128'(l1_line), 128'(0));
        @(negedge clk);
        rst = 1'b0;

        // Cold read of 0x40
        ist = issued.size();
        do_read(32'h40, st, rd, l1);
        chk("cold_stall", 128'(st), 128'(10));
        chk("cold_rdata", 128'(rd), 128'h40);
        chk("cold_l1", l1, exp_l1(32'h40));
        chk("cold_nissue", 128'(issued.size() - ist), 128'(8));
        for (int i = 0; i < 8; i++) chk($sformatf("cold_addr%0d", i), 128'(issued[ist+i]), 128'(32'h40 + i));

        do_read(32'h45, st, rd, l1);
        chk("hit_stall", 128'(st), 128'(0));
        chk("hit_rdata", 128'(rd), 128'h45);
        chk("hit_l1", l1, exp_l1(32'h44));

        // Same set 8: A=0x40, B=0xC0, C=0x140
        do_read(32'hC0, st, rd, l1);
        chk("b_stall", 128'(st), 128'(10));
        chk("b_rdata", 128'(rd), 128'hC0);
        do_read(32'h40, st, rd, l1);
        chk("a_hit_stall", 128'(st), 128'(0));
        do_read(32'h140, st, rd, l1);
        chk("c_stall", 128'(st), 128'(10));
        chk("c_rdata", 128'(rd), 128'h140);
        do_read(32'h40, st, rd, l1);
        chk("a_still_hit", 128'(st), 128'(0));
        chk("a_rdata", 128'(rd), 128'h40);
        do_read(32'hC0, st, rd, l1);
        chk("b_evicted", 128'(st), 128'(10));

        // Write hit with wait states
        nwr = n_wr_acc;
        do_write(32'h42, 32'hDEAD, 3, st);
        chk("wr_stall", 128'(st), 128'(3));
        chk("wr_count", 128'(n_wr_acc - nwr), 128'(1));
        chk("wr_addr", 128'(last_wa), 128'h42);
        chk("wr_data", 128'(last_wd), 128'hDEAD);
        do_read(32'h42, st, rd, l1);
        chk("wr_hit_stall", 128'(st), 128'(0));
        chk("wr_hit_rdata", 128'(rd), 128'hDEAD);

        // Write miss: no allocation
        nrd = n_rd_acc;
        do_write(32'h1000, 32'hBEEF, 0, st);
        chk("wmiss_stall", 128'(st), 128'(0));
        repeat (3) @(negedge clk);
        chk("wmiss_no_fill", 128'(n_rd_acc - nrd), 128'(0));
        do_read(32'h1000, st, rd, l1);
        chk("wmiss_read_stall", 128'(st), 128'(10));
        chk("wmiss_read_data", 128'(rd), 128'hBEEF);

        // Fill with random ready and return gaps
        nrd = n_rd_acc;
        ist = issued.size();
        rand_mode = 1'b1;
        do_read(32'h200, st, rd, l1);
        rand_mode = 1'b0;
        chk("rnd_count", 128'(n_rd_acc - nrd), 128'(8));
        for (int i = 0; i < 8; i++) chk($sformatf("rnd_addr%0d", i), 128'(issued[ist+i]), 128'(32'h200 + i));
        chk("rnd_rdata", 128'(rd), 128'h200);
        for (int i = 0; i < 8; i++) begin
            do_read(32'h200 + i, st, rd, l1);
            chk($sformatf("rnd_hit%0d", i), 128'(st), 128'(0));
            chk($sformatf("rnd_word%0d", i), 128'(rd), 128'(32'h200 + i));
        end

        // Reset after three fill words
        base   = n_rv;
        addr   = 32'h300;
        rd_req = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            #1;
            if (n_rv - base >= 3) break;
        end
        chk("rst_fill_words", 128'(n_rv - base), 128'(3));
        @(negedge clk);
        rst = 1'b1;
        #2;
        chk("rst_fill_stall", 128'(stall), 128'(0));
        chk("rst_fill_mem_req", 128'(mem_req), 128'(0));
        @(negedge clk);
        rst    = 1'b0;
        rd_req = 1'b0;
        repeat (6) @(negedge clk);
        chk("rst_late_drained", 128'(rq.size()), 128'(0));
        do_read(32'h300, st, rd, l1);
        chk("refill_stall", 128'(st), 128'(10));
        chk("refill_rdata", 128'(rd), 128'h300);
        chk("refill_l1", l1, exp_l1(32'h300));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
